// File: rtl/rf_seq_ctrl_if.sv
// rf_seq_ctrl_if: command handshake and register-file drive bundle.
//   cmd_valid/cmd_ready/cmd_op/cmd_arg/cmd_cnt : command channel (requester -> sequencer)
//   rf_data/rf_control                         : register-file data/control words
//   busy/done                                  : status (command in flight / completion pulse)
// master = system controller side, slave = sequencer side.
interface rf_seq_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_arg;
  logic [2:0]  cmd_cnt;
  logic [15:0] rf_data;
  logic [15:0] rf_control;
  logic        busy;
  logic        done;

  modport master (
    output cmd_valid, cmd_op, cmd_arg, cmd_cnt,
    input  cmd_ready, rf_data, rf_control, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, cmd_cnt,
    output cmd_ready, rf_data, rf_control, busy, done
  );
endinterface

// File: rtl/rf_seq_ctrl.sv
// rf_seq_ctrl: command sequencer for the 4 x 16-bit register-file datapath.
// Accepts LOAD / FILL / ROTATE / CLEAR over a valid/ready handshake and drives
// the register file control word and data input one step per cycle, then
// pulses done for one cycle.
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : rf_seq_ctrl_if.slave (command channel, rf_data/rf_control, busy, done)
module rf_seq_ctrl (
  input  logic          clk,
  input  logic          rst,
  rf_seq_ctrl_if.slave  bus
);

  localparam logic [15:0] IDLE_WORD  = 16'hFFF0;
  localparam logic [15:0] LOAD_WORD  = 16'h7FF1;
  localparam logic [15:0] SHIFT_WORD = 16'h60AF;
  localparam logic [15:0] ROT_WORD   = 16'h40AF;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_FILL = 2'b01;
  localparam logic [1:0] OP_ROT  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_DONE = 2'd2} state_t;

  state_t      r_state;
  logic [1:0]  r_op;
  logic [15:0] r_arg;
  logic [2:0]  r_last;       // N-1: final step index
  logic [2:0]  r_k;          // current step index
  logic [15:0] r_rf_data;
  logic [15:0] r_rf_control;
  logic        r_busy;
  logic        r_done;

  logic        w_accept;
  logic [2:0]  w_last_in;
  logic [2:0]  w_k_nxt;

  function automatic logic [15:0] f_op_word(input logic [1:0] op);
    case (op)
      OP_LOAD: f_op_word = LOAD_WORD;
      OP_ROT:  f_op_word = ROT_WORD;
      default: f_op_word = SHIFT_WORD;   // FILL and CLEAR shift a value in at R0
    endcase
  endfunction

  assign bus.cmd_ready  = (r_state == S_IDLE) & ~rst;
  assign bus.rf_data    = r_rf_data;
  assign bus.rf_control = r_rf_control;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

  assign w_accept = bus.cmd_valid & bus.cmd_ready;
  assign w_k_nxt  = r_k + 3'd1;

  // Rotate count 0 means 8 steps: cnt-1 in 3 bits wraps 0 to 7, which is
  // exactly the last step index needed.
  always_comb begin
    w_last_in = 3'd3;
    case (bus.cmd_op)
      OP_LOAD: w_last_in = 3'd0;
      OP_ROT:  w_last_in = bus.cmd_cnt - 3'd1;
      default: w_last_in = 3'd3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_op         <= OP_LOAD;
      r_arg        <= 16'h0000;
      r_last       <= 3'd0;
      r_k          <= 3'd0;
      r_rf_data    <= 16'h0000;
      r_rf_control <= IDLE_WORD;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            // Step 0 is registered here so it is visible right after accept.
            r_state      <= S_EXEC;
            r_op         <= bus.cmd_op;
            r_arg        <= bus.cmd_arg;
            r_last       <= w_last_in;
            r_k          <= 3'd0;
            r_busy       <= 1'b1;
            r_rf_control <= f_op_word(bus.cmd_op);
            r_rf_data    <= (bus.cmd_op == OP_LOAD || bus.cmd_op == OP_FILL) ?
                            bus.cmd_arg : 16'h0000;
          end
        end
        S_EXEC: begin
          if (r_k == r_last) begin
            r_state      <= S_DONE;
            r_rf_control <= IDLE_WORD;
            r_rf_data    <= 16'h0000;
            r_done       <= 1'b1;
          end else begin
            // LOAD has a single step, so only FILL carries data past step 0.
            r_k       <= w_k_nxt;
            r_rf_data <= (r_op == OP_FILL) ? r_arg + {13'd0, w_k_nxt} : 16'h0000;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state      <= S_IDLE;
          r_rf_control <= IDLE_WORD;
          r_rf_data    <= 16'h0000;
          r_busy       <= 1'b0;
          r_done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_seq_ctrl.sv
// tb_rf_seq_ctrl: directed + randomized bench for rf_seq_ctrl. An expected
// per-cycle output schedule is generated from the command rules, and a
// register-file model fed by the DUT's outputs is compared against the
// architectural result of each completed command.
module tb_rf_seq_ctrl;

  localparam logic [15:0] IDLE_W  = 16'hFFF0;
  localparam logic [15:0] LOAD_W  = 16'h7FF1;
  localparam logic [15:0] SHIFT_W = 16'h60AF;
  localparam logic [15:0] ROT_W   = 16'h40AF;

  typedef struct {
    logic [15:0] ctl;
    logic [15:0] dat;
    logic        busy;
    logic        done;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rf_seq_ctrl_if ifc();
  rf_seq_ctrl dut (.clk(clk), .rst(rst), .bus(ifc.slave));

  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_done = 0;
  logic acc_last;

  ent_t q[$];
  ent_t cur;

  // in-flight command (only one at a time)
  logic [1:0]  p_op;
  logic [15:0] p_arg;
  int          p_n;

  logic [15:0] rf [4];   // register file driven by the DUT's words
  logic [15:0] ar [4];   // architectural expectation
  logic [3:0]  known;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic ent_t mk(input logic [15:0] c, input logic [15:0] d,
                              input logic b, input logic dn);
    ent_t e;
    e.ctl = c; e.dat = d; e.busy = b; e.done = dn;
    return e;
  endfunction

  task automatic arch_apply();
    logic [15:0] t [4];
    logic [3:0]  tk;
    int          r;
    case (p_op)
      2'b00: begin ar[0] = p_arg; known[0] = 1'b1; end
      2'b01: begin
        for (int i = 0; i < 4; i++) ar[i] = p_arg + 16'(3 - i);
        known = 4'hF;
      end
      2'b11: begin
        for (int i = 0; i < 4; i++) ar[i] = 16'h0000;
        known = 4'hF;
      end
      default: begin
        r = p_n % 4;
        for (int i = 0; i < 4; i++) begin t[i] = ar[i]; tk[i] = known[i]; end
        for (int i = 0; i < 4; i++) begin
          ar[i]    = t[(i - r + 4) % 4];
          known[i] = tk[(i - r + 4) % 4];
        end
      end
    endcase
    for (int i = 0; i < 4; i++)
      if (known[i]) chk($sformatf("reg_r%0d", i), 32'(rf[i]), 32'(ar[i]));
  endtask

  // One clock: predict from pre-edge inputs, advance models, check after edge.
  task automatic tick();
    logic        acc;
    logic [15:0] pc, pd;
    int          n;
    logic [15:0] c;
    acc = ifc.cmd_valid && !cur.busy && !rst;
    pc  = ifc.rf_control;
    pd  = ifc.rf_data;
    @(posedge clk);
    case (pc)
      LOAD_W:  rf[0] = pd;
      SHIFT_W: begin rf[3] = rf[2]; rf[2] = rf[1]; rf[1] = rf[0]; rf[0] = pd; end
      ROT_W:   begin pd = rf[3]; rf[3] = rf[2]; rf[2] = rf[1]; rf[1] = rf[0]; rf[0] = pd; end
      default: ;
    endcase
    acc_last = acc;
    if (rst) begin
      if (cur.busy && !cur.done) known = 4'h0;
      q.delete();
      cur = mk(IDLE_W, 16'h0000, 1'b0, 1'b0);
    end else if (acc) begin
      p_op  = ifc.cmd_op;
      p_arg = ifc.cmd_arg;
      case (p_op)
        2'b00:   n = 1;
        2'b10:   n = (ifc.cmd_cnt == 3'd0) ? 8 : int'(ifc.cmd_cnt);
        default: n = 4;
      endcase
      p_n = n;
      c = (p_op == 2'b00) ? LOAD_W : (p_op == 2'b10) ? ROT_W : SHIFT_W;
      q.delete();
      for (int k = 0; k < n; k++)
        q.push_back(mk(c, (p_op == 2'b00) ? p_arg :
                          (p_op == 2'b01) ? p_arg + 16'(k) : 16'h0000, 1'b1, 1'b0));
      q.push_back(mk(IDLE_W, 16'h0000, 1'b1, 1'b1));
      cur = q.pop_front();
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else begin
      cur = mk(IDLE_W, 16'h0000, 1'b0, 1'b0);
    end
    #1;
    chk("rf_control", 32'(ifc.rf_control), 32'(cur.ctl));
    chk("rf_data",    32'(ifc.rf_data),    32'(cur.dat));
    chk("busy",       32'(ifc.busy),       32'(cur.busy));
    chk("done",       32'(ifc.done),       32'(cur.done));
    chk("cmd_ready",  32'(ifc.cmd_ready),  32'(!cur.busy && !rst));
    if (ifc.done === 1'b1) n_done++;
    if (cur.done && !rst) arch_apply();
    @(negedge clk);
  endtask

  task automatic send(input logic [1:0] op, input logic [15:0] arg, input logic [2:0] cnt);
    int t;
    ifc.cmd_valid = 1'b1; ifc.cmd_op = op; ifc.cmd_arg = arg; ifc.cmd_cnt = cnt;
    t = 0;
    do begin tick(); t++; end while (!acc_last && t < 40);
    if (!acc_last) chk("accept_timeout", 32'd0, 32'd1);
    ifc.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (cur.busy && t < 40) begin tick(); t++; end
    if (cur.busy) chk("idle_timeout", 32'd0, 32'd1);
    tick();
  endtask

  initial begin
    int d0;
    cur = mk(IDLE_W, 16'h0000, 1'b0, 1'b0);
    known = 4'h0;
    for (int i = 0; i < 4; i++) begin rf[i] = 16'h0; ar[i] = 16'h0; end
    ifc.cmd_valid = 1'b0; ifc.cmd_op = 2'b00; ifc.cmd_arg = 16'h0; ifc.cmd_cnt = 3'd0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();

    // LOAD 0101
    send(2'b00, 16'h0101, 3'd0);
    wait_idle();
    chk("load_r0", 32'(rf[0]), 32'h0101);

    // FILL FFFE, wrapping data
    send(2'b01, 16'hFFFE, 3'd0);
    wait_idle();
    chk("fill_r3", 32'(rf[3]), 32'hFFFE);
    chk("fill_r0", 32'(rf[0]), 32'h0001);

    // ROTATE 2 then ROTATE 0 (=8)
    send(2'b10, 16'h0, 3'd2);
    wait_idle();
    chk("rot2_r3", 32'(rf[3]), 32'h0000);
    chk("rot2_r2", 32'(rf[2]), 32'h0001);
    chk("rot2_r1", 32'(rf[1]), 32'hFFFE);
    chk("rot2_r0", 32'(rf[0]), 32'hFFFF);
    send(2'b10, 16'h0, 3'd0);
    wait_idle();
    chk("rot8_r0", 32'(rf[0]), 32'hFFFF);

    // second command held while busy: executes once, two done pulses
    d0 = n_done;
    send(2'b00, 16'h1234, 3'd0);
    send(2'b01, 16'h0010, 3'd0);
    wait_idle();
    tick(); tick();
    chk("two_done", 32'(n_done - d0), 32'd2);

    // reset during step 2 of CLEAR
    d0 = n_done;
    send(2'b11, 16'h0, 3'd0);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("abort_ctl", 32'(ifc.rf_control), 32'hFFF0);
    rst = 1'b0;
    tick();
    chk("abort_ready", 32'(ifc.cmd_ready), 32'd1);
    tick(); tick(); tick();
    chk("abort_no_done", 32'(n_done - d0), 32'd0);

    // valid while in reset is ignored
    rst = 1'b1;
    ifc.cmd_valid = 1'b1; ifc.cmd_op = 2'b01; ifc.cmd_arg = 16'hAAAA;
    tick();
    rst = 1'b0; ifc.cmd_valid = 1'b0;
    tick(); tick();
    chk("rst_no_exec", 32'(ifc.busy), 32'd0);

    // randomized traffic
    for (int it = 0; it < 400; it++) begin
      if (!ifc.cmd_valid && $urandom_range(0, 2) == 0) begin
        ifc.cmd_valid = 1'b1;
        ifc.cmd_op    = 2'($urandom_range(0, 3));
        ifc.cmd_arg   = 16'($urandom);
        ifc.cmd_cnt   = 3'($urandom_range(0, 7));
      end
      rst = ($urandom_range(0, 59) == 0);
      tick();
      if (acc_last) ifc.cmd_valid = 1'b0;
    end
    rst = 1'b0; ifc.cmd_valid = 1'b0;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=0", $time);
    $fatal(1);
  end

endmodule
